hamming_tx_scheduler: RTL and testbench

Arbitrated nibble scheduler that feeds the Hamming(7,4) encoder on the UART transmit path. It accepts bytes from two requesters (A: RX loopback, B: local status port) with round-robin arbitration. Each byte is split into a low and a high nibble, and the encoder's enable/data inputs are sequenced per its timing contract. The two resulting 7-bit codewords are emitted downstream to the serializer through a valid/ready handshake.

---
 rtl/hamming_tx_scheduler.sv | 138 +++++++++++++
 tb/tb_hamming_tx_scheduler.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_tx_scheduler.sv
// ============================================================================
// Module   : hamming_tx_scheduler
// Purpose  : Round-robin byte arbiter that sequences nibbles through the
//            Hamming(7,4) encoder and hands codewords to the serializer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module hamming_tx_scheduler #(
    parameter int ENC_HOLD = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_valid,
    input  logic [7:0] a_data,
    output logic       a_ready,
    input  logic       b_valid,
    input  logic [7:0] b_data,
    output logic       b_ready,
    output logic       enc_ena,
    output logic [3:0] enc_data,
    input  logic [6:0] enc_code,
    input  logic       enc_valid,
    output logic       cw_valid,
    output logic [6:0] cw_data,
    output logic       cw_last,
    output logic       cw_src,
    input  logic       cw_ready,
    output logic       busy,
    output logic       err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ENC  = 2'd1,
        S_CAPT = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    localparam logic [3:0] c_HOLD_LAST = 4'(ENC_HOLD - 1);

    state_t     r_state;
    logic [7:0] r_byte;
    logic       r_nib_sel;
    logic [3:0] r_cnt;
    logic       r_rr_last;   // 0 = A served last, 1 = B served last
    logic       r_src;
    logic [6:0] r_cw;
    logic       r_enc_ena;
    logic       r_cw_valid;
    logic       r_busy;
    logic       r_err;

    logic w_idle;
    logic w_grant_a;
    logic w_grant_b;

    // Readies are gated by rst so nothing is granted while reset is applied.
    assign w_idle    = (r_state == S_IDLE) && !rst;
    assign w_grant_a = w_idle && a_valid && (!b_valid || r_rr_last);
    assign w_grant_b = w_idle && b_valid && (!a_valid || !r_rr_last);

    assign a_ready  = w_grant_a;
    assign b_ready  = w_grant_b;
    assign enc_ena  = r_enc_ena;
    assign enc_data = r_nib_sel ? r_byte[7:4] : r_byte[3:0];
    assign cw_valid = r_cw_valid;
    assign cw_data  = r_cw;
    assign cw_last  = r_nib_sel;
    assign cw_src   = r_src;
    assign busy     = r_busy;
    assign err      = r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_byte     <= 8'h00;
            r_nib_sel  <= 1'b0;
            r_cnt      <= 4'd0;
            r_rr_last  <= 1'b1;
            r_src      <= 1'b0;
            r_cw       <= 7'h00;
            r_enc_ena  <= 1'b0;
            r_cw_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_a || w_grant_b) begin
                        r_byte    <= w_grant_a ? a_data : b_data;
                        r_src     <= w_grant_b;
                        r_rr_last <= w_grant_b;
                        r_nib_sel <= 1'b0;
                        r_cnt     <= 4'd0;
                        r_enc_ena <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= S_ENC;
                    end
                end
                S_ENC: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == c_HOLD_LAST) begin
                        r_enc_ena <= 1'b0;
                        r_state   <= S_CAPT;
                    end
                end
                S_CAPT: begin
                    // The codeword is forwarded even if the encoder flagged it invalid.
                    r_cw       <= enc_code;
                    r_cw_valid <= 1'b1;
                    if (!enc_valid) begin
                        r_err <= 1'b1;
                    end
                    r_state <= S_OUT;
                end
                S_OUT: begin
                    if (cw_ready) begin
                        r_cw_valid <= 1'b0;
                        if (!r_nib_sel) begin
                            r_nib_sel <= 1'b1;
                            r_cnt     <= 4'd0;
                            r_enc_ena <= 1'b1;
                            r_state   <= S_ENC;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hamming_tx_scheduler.sv
// ============================================================================
// Module   : tb_hamming_tx_scheduler
// Purpose  : Directed self-checking bench for hamming_tx_scheduler.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hamming_tx_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a_valid = 1'b0, b_valid = 1'b0, cw_ready = 1'b1, kill = 1'b0;
    logic [7:0] a_data = 8'h00, b_data = 8'h00;
    logic       a_ready, b_ready, enc_ena, enc_valid, cw_valid, cw_last, cw_src, busy, err;
    logic [3:0] enc_data;
    logic [6:0] enc_code, cw_data;

    logic       a2_valid = 1'b0, b2_valid = 1'b0, cw2_ready = 1'b1;
    logic [7:0] a2_data = 8'h00, b2_data = 8'h00;
    logic       a2_ready, b2_ready, enc2_ena, cw2_valid, cw2_last, cw2_src, busy2, err2;
    logic [3:0] enc2_data;
    logic [6:0] enc2_code, cw2_data;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Returns {p1,p2,p3}
    function automatic logic [2:0] par3(input logic [3:0] d);
        return {d[0] ^ d[1] ^ d[3], d[0] ^ d[2] ^ d[3], d[1] ^ d[2] ^ d[3]};
    endfunction

    function automatic logic [6:0] ham(input logic [3:0] d);
        logic [2:0] p;
        p = par3(d);
        return {p[2], p[1], d[0], p[0], d[1], d[2], d[3]};
    endfunction

    // Encoder model: parity trails the data bits by one enable.
    logic [3:0] e_d = 4'h0, e2_d = 4'h0;
    logic [2:0] e_p = 3'h0, e2_p = 3'h0;
    always @(posedge clk) begin
        if (enc_ena) begin
            e_d <= enc_data;
            e_p <= par3(e_d);
        end
        if (enc2_ena) begin
            e2_d <= enc2_data;
            e2_p <= par3(e2_d);
        end
    end
    assign enc_code  = {e_p[2], e_p[1], e_d[0], e_p[0], e_d[1], e_d[2], e_d[3]};
    assign enc_valid = ~kill;
    assign enc2_code = {e2_p[2], e2_p[1], e2_d[0], e2_p[0], e2_d[1], e2_d[2], e2_d[3]};

    hamming_tx_scheduler #(.ENC_HOLD(2)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .enc_ena(enc_ena), .enc_data(enc_data), .enc_code(enc_code), .enc_valid(enc_valid),
        .cw_valid(cw_valid), .cw_data(cw_data), .cw_last(cw_last), .cw_src(cw_src),
        .cw_ready(cw_ready), .busy(busy), .err(err)
    );

    hamming_tx_scheduler #(.ENC_HOLD(4)) dut4 (
        .clk(clk), .rst(rst),
        .a_valid(a2_valid), .a_data(a2_data), .a_ready(a2_ready),
        .b_valid(b2_valid), .b_data(b2_data), .b_ready(b2_ready),
        .enc_ena(enc2_ena), .enc_data(enc2_data), .enc_code(enc2_code), .enc_valid(1'b1),
        .cw_valid(cw2_valid), .cw_data(cw2_data), .cw_last(cw2_last), .cw_src(cw2_src),
        .cw_ready(cw2_ready), .busy(busy2), .err(err2)
    );

    task automatic test_reset();
        rst = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({a_ready, b_ready} !== 2'b00) begin
            errs++; $display("FAIL reset_readies: got %b expected 00", {a_ready, b_ready});
        end
        checks++;
        if ({enc_ena, enc_data, cw_valid, cw_data, cw_last, cw_src, busy, err} !== 17'h0) begin
            errs++; $display("FAIL reset_outputs: got %h expected 0",
                             {enc_ena, enc_data, cw_valid, cw_data, cw_last, cw_src, busy, err});
        end
        a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_byte();
        @(negedge clk);
        a_data = 8'h5A; a_valid = 1'b1; cw_ready = 1'b1;
        #1;
        checks++;
        if ({a_ready, b_ready} !== 2'b10) begin
            errs++; $display("FAIL single_grant: got %b expected 10", {a_ready, b_ready});
        end
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (c == 1) a_valid = 1'b0;
            #1;
            if (c == 1) begin
                checks++;
                if ({enc_ena, enc_data, busy} !== 6'b1_1010_1) begin
                    errs++; $display("FAIL single_enc_lo: got %b expected 1_1010_1", {enc_ena, enc_data, busy});
                end
            end
            if (c == 3) begin
                checks++;
                if ({enc_ena, cw_valid} !== 2'b00) begin
                    errs++; $display("FAIL single_capt: got %b expected 00", {enc_ena, cw_valid});
                end
            end
            if (c == 4) begin
                checks++;
                if ({cw_valid, cw_data, cw_last, cw_src} !== {1'b1, 7'h25, 1'b0, 1'b0}) begin
                    errs++; $display("FAIL single_cw_lo: got v%b d%h l%b s%b expected v1 d25 l0 s0",
                                     cw_valid, cw_data, cw_last, cw_src);
                end
            end
            if (c == 5) begin
                checks++;
                if ({enc_ena, enc_data} !== 5'b1_0101) begin
                    errs++; $display("FAIL single_enc_hi: got %b expected 1_0101", {enc_ena, enc_data});
                end
            end
            if (c == 8) begin
                checks++;
                if ({cw_valid, cw_data, cw_last, cw_src} !== {1'b1, 7'h5A, 1'b1, 1'b0}) begin
                    errs++; $display("FAIL single_cw_hi: got v%b d%h l%b s%b expected v1 d5a l1 s0",
                                     cw_valid, cw_data, cw_last, cw_src);
                end
            end
            if (c == 9) begin
                a_valid = 1'b1;
                #1;
                checks++;
                if ({a_ready, busy} !== 2'b10) begin
                    errs++; $display("FAIL single_idle_again: got %b expected 10", {a_ready, busy});
                end
                a_valid = 1'b0;
            end
        end
    endtask

    task automatic test_round_robin();
        logic       gsrc [4];
        logic [8:0] cwq  [8];
        int ng = 0, nc = 0, both = 0;
        logic dropped = 1'b0;
        logic [8:0] exp_cw;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        a_data = 8'h00; b_data = 8'hFF; a_valid = 1'b1; b_valid = 1'b1; cw_ready = 1'b1;
        #1;
        for (int c = 0; c < 45; c++) begin
            if (cw_valid && cw_ready) begin
                if (nc < 8) cwq[nc] = {cw_src, cw_last, cw_data};
                nc++;
            end
            if (a_ready && b_ready) both++;
            if ((a_ready || b_ready) && !dropped) begin
                gsrc[ng] = b_ready;
                ng++;
                if (ng == 4) begin
                    @(posedge clk); #1;
                    a_valid = 1'b0; b_valid = 1'b0; dropped = 1'b1;
                end
            end
            @(negedge clk); #1;
        end
        checks++;
        if (ng != 4 || both != 0) begin
            errs++; $display("FAIL rr_grant_count: got %0d grants %0d double expected 4 grants 0 double", ng, both);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= ng || gsrc[i] !== 1'(i % 2)) begin
                errs++; $display("FAIL rr_grant_%0d: got src %b expected %0d", i, gsrc[i], i % 2);
            end
        end
        checks++;
        if (nc != 8) begin
            errs++; $display("FAIL rr_cw_count: got %0d expected 8", nc);
        end
        for (int i = 0; i < 8 && i < nc; i++) begin
            exp_cw = {1'((i / 2) % 2), 1'(i % 2), ((i / 2) % 2 == 1) ? 7'h7F : 7'h00};
            checks++;
            if (cwq[i] !== exp_cw) begin
                errs++; $display("FAIL rr_cw_%0d: got %h expected %h", i, cwq[i], exp_cw);
            end
        end
    endtask

    task automatic test_backpressure();
        int bad = 0;
        @(negedge clk);
        cw_ready = 1'b0; a_data = 8'h3C; a_valid = 1'b1;
        #1;
        checks++;
        if (a_ready !== 1'b1) begin
            errs++; $display("FAIL bp_accept: got %b expected 1", a_ready);
        end
        @(posedge clk); #1;
        b_valid = 1'b1;
        repeat (3) @(negedge clk);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #1;
            if ({cw_valid, cw_data, cw_last, enc_ena, a_ready, b_ready} !== {1'b1, ham(4'hC), 1'b0, 3'b000})
                bad++;
        end
        checks++;
        if (bad != 0) begin
            errs++; $display("FAIL bp_stall: got %0d bad cycles expected 0 (cw %h)", bad, cw_data);
        end
        a_valid = 1'b0; b_valid = 1'b0; cw_ready = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if ({cw_valid, cw_data, cw_last} !== {1'b1, ham(4'h3), 1'b1}) begin
            errs++; $display("FAIL bp_cw_hi: got v%b d%h l%b expected v1 d%h l1", cw_valid, cw_data, cw_last, ham(4'h3));
        end
        @(negedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            errs++; $display("FAIL bp_idle: got busy %b expected 0", busy);
        end
    endtask

    task automatic test_err();
        @(negedge clk);
        a_data = 8'h96; a_valid = 1'b1; kill = 1'b1; cw_ready = 1'b1;
        @(posedge clk); #1;
        a_valid = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if ({err, cw_valid} !== 2'b11) begin
            errs++; $display("FAIL err_set: got err %b cw_valid %b expected 1 1", err, cw_valid);
        end
        kill = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if ({err, busy} !== 2'b10) begin
            errs++; $display("FAIL err_sticky: got err %b busy %b expected 1 0", err, busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (err !== 1'b0) begin
            errs++; $display("FAIL err_clear: got %b expected 0", err);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        @(negedge clk);
        a_data = 8'hA5; a_valid = 1'b1; cw_ready = 1'b1;
        @(posedge clk); #1;
        a_valid = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if ({enc_ena, cw_last, enc_data} !== 6'b1_1_1010) begin
            errs++; $display("FAIL mid_in_enc_hi: got %b expected 1_1_1010", {enc_ena, cw_last, enc_data});
        end
        #1; rst = 1'b1; #1;
        checks++;
        if ({a_ready, b_ready, enc_ena, enc_data, cw_valid, cw_data, cw_last, cw_src, busy, err} !== 19'h0) begin
            errs++; $display("FAIL mid_rst_outputs: got %h expected 0",
                             {a_ready, b_ready, enc_ena, enc_data, cw_valid, cw_data, cw_last, cw_src, busy, err});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk); #1;
            if (cw_valid || busy) seen++;
        end
        checks++;
        if (seen != 0) begin
            errs++; $display("FAIL mid_no_cw: got %0d active cycles expected 0", seen);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; a_data = 8'h11; a_valid = 1'b1;
        #1;
        checks++;
        if (a_ready !== 1'b1) begin
            errs++; $display("FAIL mid_first_accept: got %b expected 1", a_ready);
        end
        @(posedge clk); #1;
        a_valid = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if ({cw_valid, cw_data, cw_last} !== {1'b1, 7'h70, 1'b0}) begin
            errs++; $display("FAIL mid_new_cw: got v%b d%h l%b expected v1 d70 l0", cw_valid, cw_data, cw_last);
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_hold4();
        int ena_lo = 0, ena_hi = 0;
        @(negedge clk);
        a2_data = 8'h0F; a2_valid = 1'b1;
        #1;
        checks++;
        if (a2_ready !== 1'b1) begin
            errs++; $display("FAIL h4_accept: got %b expected 1", a2_ready);
        end
        @(posedge clk); #1;
        a2_valid = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk); #1;
            if (c <= 6 && enc2_ena) ena_lo++;
            if (c >= 7 && c <= 12 && enc2_ena) ena_hi++;
            if (c == 6) begin
                checks++;
                if ({cw2_valid, cw2_data, cw2_last} !== {1'b1, 7'h7F, 1'b0}) begin
                    errs++; $display("FAIL h4_cw_lo: got v%b d%h l%b expected v1 d7f l0", cw2_valid, cw2_data, cw2_last);
                end
            end
            if (c == 12) begin
                checks++;
                if ({cw2_valid, cw2_data, cw2_last} !== {1'b1, 7'h00, 1'b1}) begin
                    errs++; $display("FAIL h4_cw_hi: got v%b d%h l%b expected v1 d00 l1", cw2_valid, cw2_data, cw2_last);
                end
            end
            if (c == 13) begin
                checks++;
                if (busy2 !== 1'b0) begin
                    errs++; $display("FAIL h4_idle: got busy %b expected 0", busy2);
                end
            end
        end
        checks++;
        if (ena_lo != 4 || ena_hi != 4) begin
            errs++; $display("FAIL h4_ena_cycles: got %0d/%0d expected 4/4", ena_lo, ena_hi);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_byte();
        test_round_robin();
        test_backpressure();
        test_err();
        test_reset_mid();
        test_hold4();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

`default_nettype wire
